// File: rtl/usb_rx_bit_frontend.sv
// usb_rx_bit_frontend
// USB full-speed receive bit front end. Synchronises D+/D-, NRZI-decodes on
// each sample strobe, strips stuffed bits, frames packets (SYNC .. EOP) and
// assembles LSB-first words of DATA_W bits. All outputs are registered; every
// pulse lasts one clk and follows the strobe edge that caused it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus idle, waiting for the first K of a SYNC pattern
// SYNC      | collecting decoded bits until KJKJKJKK is recognised
// DATA      | payload: de-stuffing, word assembly, SE0/SE1 detection
// EOP_WAIT  | counting SE0 samples, expecting J to close the packet
// ABORT     | error seen; ignoring line until SE0 followed by J
module usb_rx_bit_frontend #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6,
  parameter int SE0_MIN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_plus,
  input  logic              d_minus,
  input  logic              sample_en,
  output logic              d_orig,
  output logic              bit_valid,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              sop,
  output logic              eop,
  output logic              rx_err,
  output logic              rx_active
);

  localparam int BW = $clog2(DATA_W);
  localparam int OW = $clog2(STUFF_LEN + 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SYNC     = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_EOP_WAIT = 3'd3;
  localparam logic [2:0] ST_ABORT    = 3'd4;

  // Index of the last SYNC-state sample before giving up (16 samples).
  localparam logic [4:0] SYNC_LAST = 5'd15;

  logic dp_meta, dp_sync, dm_meta, dm_sync;

  logic [1:0] line_st;
  logic       line_jk;
  logic       dec_bit;

  logic [2:0]        state, state_n;
  logic [1:0]        prev_ls, prev_ls_n;
  logic [2:0]        sync_zeros, sync_zeros_n;
  logic [4:0]        sync_cnt, sync_cnt_n;
  logic [OW-1:0]     ones_cnt, ones_cnt_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] asm_reg, asm_n;
  logic [1:0]        se0_cnt, se0_cnt_n;
  logic              abort_se0, abort_se0_n;

  logic              d_orig_n, bit_valid_n, data_valid_n;
  logic              sop_n, eop_n, rx_err_n, rx_active_n;
  logic [DATA_W-1:0] data_n;

  // Two-flop synchroniser on the raw line; resets to the idle J state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_meta <= 1'b1;
      dp_sync <= 1'b1;
      dm_meta <= 1'b0;
      dm_sync <= 1'b0;
    end else begin
      dp_meta <= d_plus;
      dp_sync <= dp_meta;
      dm_meta <= d_minus;
      dm_sync <= dm_meta;
    end
  end

  // Classify the synchronised line and NRZI-decode against the last J/K sample.
  always_comb begin
    line_st = {dp_sync, dm_sync};
    line_jk = (line_st == LS_J) || (line_st == LS_K);
    dec_bit = (line_st == prev_ls);
  end

  // Next-state and output logic; nothing but the pulses moves without a strobe.
  always_comb begin
    state_n      = state;
    prev_ls_n    = prev_ls;
    sync_zeros_n = sync_zeros;
    sync_cnt_n   = sync_cnt;
    ones_cnt_n   = ones_cnt;
    bit_cnt_n    = bit_cnt;
    asm_n        = asm_reg;
    se0_cnt_n    = se0_cnt;
    abort_se0_n  = abort_se0;
    d_orig_n     = d_orig;
    data_n       = data;
    rx_active_n  = rx_active;
    bit_valid_n  = 1'b0;
    data_valid_n = 1'b0;
    sop_n        = 1'b0;
    eop_n        = 1'b0;
    rx_err_n     = 1'b0;

    if (sample_en) begin
      if (line_jk) begin
        prev_ls_n = line_st;
        d_orig_n  = dec_bit;
      end

      case (state)
        ST_IDLE: begin
          if (line_st == LS_K) begin
            state_n      = ST_SYNC;
            // A cleared 8-bit window holds only zeros, so it already counts
            // as a full run of seven preceding zeros.
            sync_zeros_n = 3'd7;
            sync_cnt_n   = '0;
          end
        end

        ST_SYNC: begin
          // Window == 8'h80 means the newest bit is 1 and the seven before it
          // are 0, so tracking the trailing zero run is sufficient.
          if (line_st == LS_SE0) begin
            state_n = ST_IDLE;
          end else if (line_jk && dec_bit && (sync_zeros == 3'd7)) begin
            state_n     = ST_DATA;
            sop_n       = 1'b1;
            rx_active_n = 1'b1;
            bit_cnt_n   = '0;
            ones_cnt_n  = '0;
          end else begin
            if (line_jk) begin
              if (dec_bit) begin
                sync_zeros_n = 3'd0;
              end else if (sync_zeros != 3'd7) begin
                sync_zeros_n = sync_zeros + 3'd1;
              end
            end
            if (sync_cnt == SYNC_LAST) begin
              state_n = ST_IDLE;
            end else begin
              sync_cnt_n = sync_cnt + 5'd1;
            end
          end
        end

        ST_DATA: begin
          if (line_st == LS_SE0) begin
            state_n   = ST_EOP_WAIT;
            se0_cnt_n = 2'd1;
          end else if (!line_jk) begin
            rx_err_n    = 1'b1;
            state_n     = ST_ABORT;
            abort_se0_n = 1'b0;
          end else if (ones_cnt == OW'(STUFF_LEN)) begin
            if (dec_bit) begin
              rx_err_n    = 1'b1;
              state_n     = ST_ABORT;
              abort_se0_n = 1'b0;
            end else begin
              ones_cnt_n = '0;
            end
          end else begin
            ones_cnt_n         = dec_bit ? (ones_cnt + 1'b1) : '0;
            bit_valid_n        = 1'b1;
            // Writing by position gives the same word as shifting into the
            // MSB, and every position is rewritten before each word completes.
            asm_n[bit_cnt]     = dec_bit;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              data_n       = asm_n;
              data_valid_n = 1'b1;
              bit_cnt_n    = '0;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end

        ST_EOP_WAIT: begin
          case (line_st)
            LS_SE0: begin
              if (se0_cnt != 2'd3) begin
                se0_cnt_n = se0_cnt + 2'd1;
              end
            end
            LS_J: begin
              if (se0_cnt >= 2'(SE0_MIN)) begin
                eop_n       = 1'b1;
                rx_active_n = 1'b0;
                state_n     = ST_IDLE;
              end else begin
                rx_err_n    = 1'b1;
                state_n     = ST_ABORT;
                abort_se0_n = 1'b0;
              end
            end
            default: begin
              rx_err_n    = 1'b1;
              state_n     = ST_ABORT;
              abort_se0_n = 1'b0;
            end
          endcase
        end

        ST_ABORT: begin
          case (line_st)
            LS_SE0: abort_se0_n = 1'b1;
            LS_J: begin
              if (abort_se0) begin
                eop_n       = 1'b1;
                rx_active_n = 1'b0;
                state_n     = ST_IDLE;
                abort_se0_n = 1'b0;
              end
            end
            default: abort_se0_n = 1'b0;
          endcase
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Register FSM state, counters and all outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prev_ls    <= LS_J;
      sync_zeros <= '0;
      sync_cnt   <= '0;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      asm_reg    <= '0;
      se0_cnt    <= '0;
      abort_se0  <= 1'b0;
      d_orig     <= 1'b1;
      bit_valid  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      rx_err     <= 1'b0;
      rx_active  <= 1'b0;
    end else begin
      state      <= state_n;
      prev_ls    <= prev_ls_n;
      sync_zeros <= sync_zeros_n;
      sync_cnt   <= sync_cnt_n;
      ones_cnt   <= ones_cnt_n;
      bit_cnt    <= bit_cnt_n;
      asm_reg    <= asm_n;
      se0_cnt    <= se0_cnt_n;
      abort_se0  <= abort_se0_n;
      d_orig     <= d_orig_n;
      bit_valid  <= bit_valid_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      sop        <= sop_n;
      eop        <= eop_n;
      rx_err     <= rx_err_n;
      rx_active  <= rx_active_n;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_frontend.sv
// Bench for usb_rx_bit_frontend: two instances (8- and 16-bit words) share the
// same line stimulus; a packet-level model predicts every output each cycle.
module tb_usb_rx_bit_frontend;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam logic [1:0] LSE1 = 2'b11;
  localparam int STUFF = 6;
  localparam int SE0M  = 2;

  logic clk = 1'b0;
  logic rst, d_plus, d_minus, sample_en;

  logic        o8_dorig, o8_bv, o8_dv, o8_sop, o8_eop, o8_err, o8_act;
  logic [7:0]  o8_data;
  logic        o16_dorig, o16_bv, o16_dv, o16_sop, o16_eop, o16_err, o16_act;
  logic [15:0] o16_data;

  always #5 clk = ~clk;

  usb_rx_bit_frontend #(.DATA_W(8), .STUFF_LEN(STUFF), .SE0_MIN(SE0M)) u_dut8 (
    .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus), .sample_en(sample_en),
    .d_orig(o8_dorig), .bit_valid(o8_bv), .data(o8_data), .data_valid(o8_dv),
    .sop(o8_sop), .eop(o8_eop), .rx_err(o8_err), .rx_active(o8_act));

  usb_rx_bit_frontend #(.DATA_W(16), .STUFF_LEN(STUFF), .SE0_MIN(SE0M)) u_dut16 (
    .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus), .sample_en(sample_en),
    .d_orig(o16_dorig), .bit_valid(o16_bv), .data(o16_data), .data_valid(o16_dv),
    .sop(o16_sop), .eop(o16_eop), .rx_err(o16_err), .rx_active(o16_act));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Framing is independent of word width, so one phase drives both instances.
  // phase: 0 idle, 1 hunting sync, 2 payload, 3 after SE0, 4 aborted
  int          phase = 0;
  logic [1:0]  h1 = LJ, h2 = LJ, m_prev = LJ;
  bit          sq[$];
  int          scnt, run, se0c;
  bit          seen;
  int          nb[2];
  logic [31:0] acc[2];
  bit          mvalid = 1'b0;
  bit          e_dorig = 1'b1, e_bv, e_sop, e_eop, e_err, e_act;
  bit          e_dv[2];
  logic [31:0] e_data[2];
  logic [31:0] mq0[$], mq1[$];

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  task automatic go_abort();
    e_err = 1'b1;
    phase = 4;
    seen  = 1'b0;
  endtask

  task automatic step(input logic [1:0] ls, input bit jk, input bit b);
    bit hit;
    hit = 1'b0;
    if (jk) e_dorig = b;
    case (phase)
      0: if (ls == LK) begin
        phase = 1;
        sq.delete();
        repeat (8) sq.push_back(1'b0);
        scnt = 0;
      end
      1: if (ls == LSE0) phase = 0;
      else begin
        scnt++;
        if (jk) begin
          sq.push_back(b);
          void'(sq.pop_front());
          hit = sq[7];
          for (int k = 0; k < 7; k++) if (sq[k]) hit = 1'b0;
        end
        if (hit) begin
          phase = 2; e_sop = 1'b1; e_act = 1'b1; run = 0;
          for (int i = 0; i < 2; i++) begin nb[i] = 0; acc[i] = 0; end
        end else if (scnt >= 16) phase = 0;
      end
      2: if (ls == LSE0) begin
        phase = 3; se0c = 1;
      end else if (ls == LSE1) go_abort();
      else if (run == STUFF) begin
        if (b) go_abort(); else run = 0;
      end else begin
        run  = b ? run + 1 : 0;
        e_bv = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (b) acc[i] = acc[i] | (32'd1 << nb[i]);
          nb[i]++;
          if (nb[i] == wid(i)) begin
            e_data[i] = acc[i]; e_dv[i] = 1'b1;
            if (i == 0) mq0.push_back(acc[i]); else mq1.push_back(acc[i]);
            acc[i] = 0; nb[i] = 0;
          end
        end
      end
      3: if (ls == LSE0) se0c++;
      else if (ls == LJ && se0c >= SE0M) begin
        e_eop = 1'b1; e_act = 1'b0; phase = 0;
      end else go_abort();
      default: if (ls == LSE0) seen = 1'b1;
      else if (ls == LJ) begin
        if (seen) begin e_eop = 1'b1; e_act = 1'b0; phase = 0; seen = 1'b0; end
      end else seen = 1'b0;
    endcase
  endtask

  // Model advances on the same edges as the DUT, with a two-edge line delay.
  always @(posedge clk) begin : model
    logic [1:0] ls;
    bit jk, b;
    e_bv = 0; e_sop = 0; e_eop = 0; e_err = 0; e_dv[0] = 0; e_dv[1] = 0;
    if (rst) begin
      mvalid = 1'b1; h1 = LJ; h2 = LJ; m_prev = LJ; phase = 0; seen = 0;
      e_dorig = 1'b1; e_act = 1'b0; e_data[0] = 0; e_data[1] = 0;
    end else begin
      ls = h2; h2 = h1; h1 = {d_plus, d_minus};
      if (sample_en) begin
        jk = (ls == LJ) || (ls == LK);
        b  = (ls == m_prev);
        if (jk) m_prev = ls;
        step(ls, jk, b);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("d_orig", 0, 32'(o8_dorig), 32'(e_dorig));
      chk("bit_valid", 0, 32'(o8_bv), 32'(e_bv));
      chk("data", 0, 32'(o8_data), e_data[0]);
      chk("data_valid", 0, 32'(o8_dv), 32'(e_dv[0]));
      chk("sop", 0, 32'(o8_sop), 32'(e_sop));
      chk("eop", 0, 32'(o8_eop), 32'(e_eop));
      chk("rx_err", 0, 32'(o8_err), 32'(e_err));
      chk("rx_active", 0, 32'(o8_act), 32'(e_act));
      chk("d_orig", 1, 32'(o16_dorig), 32'(e_dorig));
      chk("bit_valid", 1, 32'(o16_bv), 32'(e_bv));
      chk("data", 1, 32'(o16_data), e_data[1]);
      chk("data_valid", 1, 32'(o16_dv), 32'(e_dv[1]));
      chk("sop", 1, 32'(o16_sop), 32'(e_sop));
      chk("eop", 1, 32'(o16_eop), 32'(e_eop));
      chk("rx_err", 1, 32'(o16_err), 32'(e_err));
      chk("rx_active", 1, 32'(o16_act), 32'(e_act));
    end
  end

  // ---------------- event counters from the DUTs ----------------
  int n_sop[2], n_eop[2], n_err[2], n_dv[2], n_bv[2];
  logic [31:0] wq0[$], wq1[$];

  always @(negedge clk) begin
    if (o8_sop) n_sop[0]++;
    if (o8_eop) n_eop[0]++;
    if (o8_err) n_err[0]++;
    if (o8_bv) n_bv[0]++;
    if (o8_dv) begin n_dv[0]++; wq0.push_back(32'(o8_data)); end
    if (o16_sop) n_sop[1]++;
    if (o16_eop) n_eop[1]++;
    if (o16_err) n_err[1]++;
    if (o16_bv) n_bv[1]++;
    if (o16_dv) begin n_dv[1]++; wq1.push_back(32'(o16_data)); end
  end

  int b_sop[2], b_eop[2], b_err[2], b_dv[2], b_bv[2];
  int w0, w1, m0, m1;

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_sop[i] = n_sop[i]; b_eop[i] = n_eop[i]; b_err[i] = n_err[i];
      b_dv[i] = n_dv[i]; b_bv[i] = n_bv[i];
    end
    w0 = wq0.size(); w1 = wq1.size(); m0 = mq0.size(); m1 = mq1.size();
  endtask

  task automatic expect_counts(input string tag, input int sp, input int ep, input int er,
                               input int bv, input int dv8, input int dv16);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_sop_count"}, i, n_sop[i] - b_sop[i], sp);
      chk({tag, "_eop_count"}, i, n_eop[i] - b_eop[i], ep);
      chk({tag, "_err_count"}, i, n_err[i] - b_err[i], er);
      chk({tag, "_bitvalid_count"}, i, n_bv[i] - b_bv[i], bv);
      chk({tag, "_rx_active_end"}, i, (i == 0) ? 32'(o8_act) : 32'(o16_act), 0);
    end
    chk({tag, "_dv_count"}, 0, n_dv[0] - b_dv[0], dv8);
    chk({tag, "_dv_count"}, 1, n_dv[1] - b_dv[1], dv16);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] cur = LJ;

  task automatic send_ls(input logic [1:0] ls);
    @(negedge clk);
    {d_plus, d_minus} = ls;
    repeat (2) @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    if (!b) cur = (cur == LJ) ? LK : LJ;
    send_ls(cur);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) send_bit(v[k]);
  endtask

  task automatic send_sync();
    cur = LJ;
    send_bits(32'h80, 8);
  endtask

  task automatic send_eop(input int n_se0);
    repeat (n_se0) send_ls(LSE0);
    cur = LJ;
    send_ls(LJ);
  endtask

  task automatic idle(input int n);
    cur = LJ;
    repeat (n) send_ls(LJ);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; {d_plus, d_minus} = LJ;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values with idle line.
    chk("rst_d_orig", 0, 32'(o8_dorig), 1);
    chk("rst_data", 0, 32'(o8_data), 0);
    chk("rst_rx_active", 0, 32'(o8_act), 0);
    chk("rst_data", 1, 32'(o16_data), 0);

    // 20 back-to-back J strobes: nothing happens.
    snap();
    @(negedge clk); sample_en = 1'b1;
    repeat (20) @(negedge clk);
    sample_en = 1'b0;
    expect_counts("idle", 0, 0, 0, 0, 0, 0);

    // SYNC, 0xA5, 0x3C, SE0 x2, J.
    snap();
    send_sync(); send_bits(32'hA5, 8); send_bits(32'h3C, 8); send_eop(2);
    expect_counts("two_bytes", 1, 1, 0, 16, 2, 1);
    chk("two_bytes_word0", 0, wq0[w0], 32'hA5);
    chk("two_bytes_word1", 0, wq0[w0 + 1], 32'h3C);
    chk("two_bytes_word", 1, wq1[w1], 32'h3CA5);
    chk("model_two_bytes_word0", 0, mq0[m0], 32'hA5);
    chk("model_two_bytes_word", 1, mq1[m1], 32'h3CA5);
    idle(2);

    // 0xFF 0xFF with a stuffed 0 after every six 1s.
    snap();
    send_sync();
    send_bits(32'h3F, 6); send_bit(1'b0);
    send_bits(32'h3F, 6); send_bit(1'b0);
    send_bits(32'hF, 4);
    send_eop(2);
    expect_counts("stuffed", 1, 1, 0, 16, 2, 1);
    chk("stuffed_word0", 0, wq0[w0], 32'hFF);
    chk("stuffed_word1", 0, wq0[w0 + 1], 32'hFF);
    chk("stuffed_word", 1, wq1[w1], 32'hFFFF);
    idle(2);

    // Seven 1s: stuff error, abort, then SE0 SE0 J.
    snap();
    send_sync(); send_bits(32'h7F, 7); send_eop(2);
    expect_counts("stuff_err", 1, 1, 1, 6, 0, 0);
    idle(2);

    // 0x1234 plus five extra bits: partial word dropped.
    snap();
    send_sync(); send_bits(32'h1234, 16); send_bits(32'h0D, 5); send_eop(2);
    expect_counts("partial", 1, 1, 0, 21, 2, 1);
    chk("partial_word", 1, wq1[w1], 32'h1234);
    chk("partial_word0", 0, wq0[w0], 32'h34);
    chk("partial_word1", 0, wq0[w0 + 1], 32'h12);
    chk("model_partial_word", 1, mq1[m1], 32'h1234);
    idle(2);

    // Reset after three payload bits, then a fresh packet.
    snap();
    send_sync(); send_bits(32'h5, 3);
    @(negedge clk); rst = 1'b1; {d_plus, d_minus} = LJ; cur = LJ;
    @(negedge clk); rst = 1'b0;
    chk("reset_mid_rx_active", 0, 32'(o8_act), 0);
    chk("reset_mid_rx_active", 1, 32'(o16_act), 0);
    idle(2);
    send_sync(); send_bits(32'hA5, 8); send_eop(2);
    expect_counts("after_reset", 2, 1, 0, 11, 1, 0);
    chk("after_reset_word", 0, wq0[w0], 32'hA5);
    idle(2);

    // One SE0 then J with SE0_MIN=2: error, then SE0 J closes the abort.
    snap();
    send_sync(); send_bits(32'hA5, 8);
    send_ls(LSE0); cur = LJ; send_ls(LJ);
    send_eop(1);
    expect_counts("short_se0", 1, 1, 1, 8, 1, 0);
    idle(2);

    // SE1 inside the payload.
    snap();
    send_sync(); send_bits(32'h2, 3); send_ls(LSE1); send_eop(2);
    expect_counts("se1", 1, 1, 1, 3, 0, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
